muxn_rr: RTL
============

Name: muxn_rr

Overview:
- N-channel, n-bit arbitrated multiplexer. Successor to the combinational 2:1/4:1 muxes.
- Each input channel has a valid/ready handshake. A round-robin arbiter selects the channel.
- The selected word is captured in a one-entry output register with its own valid/ready handshake.
- Used wherever several producers (e.g. writeback sources, memory requesters) share one downstream consumer.

Parameters:
- n, 32, data width per channel in bits.
- N, 4, number of input channels (N >= 2, need not be a power of two).
- SW, $clog2(N), select/grant width (localparam, derived; not overridable).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*n  channel i occupies bits [i*n +: n].
- in_valid  input  N  channel i has a word.
- in_ready  output  N  channel i's word is taken this cycle (one-hot or zero).
- out_data  output  n  registered selected word.
- out_sel  output  SW  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset: sampled on clk rising edge only. Values after reset:
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=N-1, so channel 0 has first priority.
  - Reset overrides any handshake in the same cycle; a word held at reset is discarded.
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load enable: ld = ~out_valid | out_ready.
- Arbitration (combinational):
  - Search channels ptr+1, ptr+2, ... modulo N. Wrap from N-1 to 0.
  - The grant g is the first channel with in_valid=1.
  - No grant if in_valid==0.
- in_ready[i] = ld & grant_valid & (i==g). At most one bit set.
  - in_ready may depend combinationally on in_valid and out_ready.
  - in_valid must not depend on in_ready.
- Transfer on the rising edge where ld & grant_valid:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= g.
- Drain without refill (out_valid & out_ready & ~grant_valid): out_valid <= 0. out_data and out_sel hold their last values.
- FULL & ~out_ready: all registers hold; in_ready=0.
- Simultaneous drain and refill (FULL & out_ready & grant_valid): new word loads the same cycle; out_valid stays 1. Sustained throughput is 1 word/cycle.
- Latency: input handshake to out_valid is 1 cycle.
- Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
  - No channel waits more than N-1 transfers once valid.
- Pointer is unchanged when there is no transfer.
- Producer rule: a channel holding valid without ready must keep in_data stable. The block does not check this.

Optional Feature:
- Macro: MUXN_FIXED_PRI_EN.
- When defined:
  - Arbitration is fixed priority: lowest-index valid channel wins.
  - ptr is removed and never updates.
  - All other handshake and register behaviour is unchanged.
  - Starvation of high-index channels is permitted.
- When undefined: round-robin as specified above.

Test Plan:
1. Reset release (n=32, N=4): hold reset 2 cycles with in_valid=4'b1111 -> in_ready=0 during reset. After release: out_valid=0, out_data=0, out_sel=0. First transfer grants channel 0.
2. Round-robin rotation: in_valid=4'b1111, in_data ch i = 32'hA000_000i, out_ready=1 held for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, one word per cycle, out_data matching.
3. Backpressure: out FULL with ch2 word 32'hA000_0002, out_ready=0 for 3 cycles, in_valid=4'b1011 -> in_ready=0 and out_data/out_sel/out_valid stable. When out_ready=1, the next load is ch3 (ptr=2, search 3,0,1).
4. Sparse/wrap: only ch3 valid, then only ch0 valid next cycle, out_ready=1 -> out_sel=3 then 0. After ch0 transfer, out_valid falls the cycle after in_valid=0.
5. Reset mid-operation: FULL with out_sel=2, assert reset with out_ready=1 and in_valid=4'b0100 -> next edge out_valid=0, ptr reset. After release, a fresh request from ch1 and ch0 grants ch0.
6. MUXN_FIXED_PRI_EN build: in_valid=4'b1111, out_ready=1 for 4 cycles -> out_sel=0 every cycle. Drop ch0 -> out_sel=1.

Source files
------------

// File: rtl/muxn_rr.sv
// N-channel valid/ready multiplexer: round-robin arbiter feeding a one-entry output register.
// Define MUXN_FIXED_PRI_EN to replace round-robin with fixed lowest-index-first priority.
module muxn_rr #(
  parameter int n = 32,
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N*n-1:0]        in_data,
  input  logic [N-1:0]          in_valid,
  output logic [N-1:0]          in_ready,
  output logic [n-1:0]          out_data,
  output logic [$clog2(N)-1:0]  out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int SW = $clog2(N);

  logic [n-1:0]  ch [N];
  logic          out_valid_q, out_valid_d;
  logic [n-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] gnt;
  logic          gnt_vld;
  logic          ld;
  logic          xfer;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch[i] = in_data[i*n +: n];
  end

  // Reset blocks the handshake so no producer sees its word taken while it is being discarded.
  assign ld   = (~out_valid_q | out_ready) & ~reset;
  assign xfer = ld & gnt_vld;

`ifdef MUXN_FIXED_PRI_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        gnt_vld = 1'b1;
        gnt     = SW'(k);
      end
    end
  end
`else
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] idx;

  // Search starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = SW'((int'(ptr_q) + k) % N);
      if (!gnt_vld && in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= SW'(N - 1);
    else       ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  // A drain with nothing to refill empties the register but keeps the last word visible.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch[gnt];
      out_sel_d   = gnt;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer & (gnt == SW'(i));
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
